// File: rtl/alu_pkg.sv
// Shared constants and types for the 32-bit ALU add/sub datapath.
// Operand widths, opcode encodings and the flag bundle.
package alu_pkg;

  localparam int HALF  = 16;
  localparam int WIDTH = 2 * HALF;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic c;
    logic z;
    logic n;
    logic v;
  } flags_t;

endpackage

// File: rtl/prefix16_core.sv
// 16-bit Sklansky parallel-prefix adder slice.
// Purely combinational; cin folds into the final carry step.
module prefix16_core
  import alu_pkg::*;
(
  input  logic [HALF-1:0] a,
  input  logic [HALF-1:0] b,
  input  logic            cin,
  output logic [HALF-1:0] sum,
  output logic            cout
);

  localparam int LVLS = $clog2(HALF);

  logic [LVLS:0][HALF-1:0] g;
  logic [LVLS:0][HALF-1:0] p;
  logic [HALF:0]           c;

  assign g[0] = a & b;
  assign p[0] = a ^ b;

  // Each level merges a block with the top bit of the block below it.
  for (genvar k = 0; k < LVLS; k++) begin : g_lvl
    for (genvar i = 0; i < HALF; i++) begin : g_bit
      if (((i >> k) & 1) == 1) begin : g_merge
        localparam int J = ((i >> k) << k) - 1;
        assign g[k+1][i] = g[k][i] | (p[k][i] & g[k][J]);
        assign p[k+1][i] = p[k][i] & p[k][J];
      end else begin : g_pass
        assign g[k+1][i] = g[k][i];
        assign p[k+1][i] = p[k][i];
      end
    end
  end

  assign c[0] = cin;

  // Group generate/propagate over [i:0] plus cin gives carry into i+1.
  for (genvar i = 0; i < HALF; i++) begin : g_carry
    assign c[i+1] = g[LVLS][i] | (p[LVLS][i] & cin);
  end

  assign sum  = p[0] ^ c[HALF-1:0];
  assign cout = c[HALF];

endmodule

// File: rtl/prefix_addsub32_pipe.sv
// Two-stage 32-bit add/sub: low half in stage 1, high half and
// flags in stage 2, valid/ready on both sides.
module prefix_addsub32_pipe
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_c,
  output logic             out_z,
  output logic             out_n,
  output logic             out_v
);

  logic [WIDTH-1:0] bp;
  logic [HALF-1:0]  lo_sum_d;
  logic             lo_c_d;

  logic             s1_valid;
  logic [HALF-1:0]  lo_sum;
  logic             lo_c;
  logic [HALF-1:0]  a_hi;
  logic [HALF-1:0]  bp_hi;

  logic [HALF-1:0]  hi_sum;
  logic             hi_c;
  logic [WIDTH-1:0] res_d;
  flags_t           flags_d;
  flags_t           flags;

  logic out_fire;
  logic s2_adv;
  logic accept;

  assign bp = (in_op == OP_SUB) ? ~in_b : in_b;

  prefix16_core u_lo (
    .a    (in_a[HALF-1:0]),
    .b    (bp[HALF-1:0]),
    .cin  (in_op),
    .sum  (lo_sum_d),
    .cout (lo_c_d)
  );

  prefix16_core u_hi (
    .a    (a_hi),
    .b    (bp_hi),
    .cin  (lo_c),
    .sum  (hi_sum),
    .cout (hi_c)
  );

  assign res_d     = {hi_sum, lo_sum};
  assign flags_d.c = hi_c;
  assign flags_d.z = (res_d == '0);
  assign flags_d.n = hi_sum[HALF-1];
  assign flags_d.v = (a_hi[HALF-1] == bp_hi[HALF-1])
                   && (hi_sum[HALF-1] != a_hi[HALF-1]);

  assign out_fire = out_valid & out_ready;
  assign s2_adv   = s1_valid & (~out_valid | out_ready);
  assign in_ready = ~s1_valid | s2_adv;
  assign accept   = in_valid & in_ready;

  // Stage 1: low-half sum and carry, high operand halves held for stage 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      lo_sum   <= '0;
      lo_c     <= 1'b0;
      a_hi     <= '0;
      bp_hi    <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        lo_sum   <= lo_sum_d;
        lo_c     <= lo_c_d;
        a_hi     <= in_a[WIDTH-1:HALF];
        bp_hi    <= bp[WIDTH-1:HALF];
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2: result and flags load only when stage 1 advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_res   <= '0;
      flags     <= '0;
    end else begin
      if (s2_adv) begin
        out_valid <= 1'b1;
        out_res   <= res_d;
        flags     <= flags_d;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign out_c = flags.c;
  assign out_z = flags.z;
  assign out_n = flags.n;
  assign out_v = flags.v;

endmodule

// File: tb/tb_prefix_addsub32_pipe.sv
// Scoreboard bench for prefix_addsub32_pipe: directed corner
// cases, streaming, stalls, mid-flight reset and random traffic.
module tb_prefix_addsub32_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_op = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_res;
  logic        out_c, out_z, out_n, out_v;

  typedef struct {
    logic [31:0] r;
    logic [3:0]  f;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  bit   done = 0;

  prefix_addsub32_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_c     (out_c),
    .out_z     (out_z),
    .out_n     (out_n),
    .out_v     (out_v)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Reference: plain 33-bit and signed 64-bit arithmetic.
  function automatic exp_t model(input logic [31:0] a,
                                 input logic [31:0] b,
                                 input logic op);
    exp_t   e;
    longint sr;
    logic [32:0] w;
    logic c, v;
    if (op) begin
      w  = {1'b0, a} - {1'b0, b};
      c  = (a >= b);
      sr = longint'($signed(a)) - longint'($signed(b));
    end else begin
      w  = {1'b0, a} + {1'b0, b};
      c  = w[32];
      sr = longint'($signed(a)) + longint'($signed(b));
    end
    v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    e.r = w[31:0];
    e.f = {c, (w[31:0] == 32'h0), w[31], v};
    e.cyc = 0;
    return e;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] x;
    case ($urandom_range(0, 7))
      0: x = 32'h0000_0000;
      1: x = 32'hFFFF_FFFF;
      2: x = 32'h8000_0000;
      3: x = 32'h7FFF_FFFF;
      4: x = 32'h0000_FFFF;
      5: x = $urandom & 32'h0001_FFFF;
      default: x = $urandom;
    endcase
    return x;
  endfunction

  task automatic send(input logic [31:0] a,
                      input logic [31:0] b,
                      input logic op,
                      input logic [31:0] r,
                      input logic [3:0] f);
    bit ok = 0;
    exp_t e;
    @(posedge clk); #2;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_op = op;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) begin
        e.r = r;
        e.f = f;
        e.cyc = cyc;
        q.push_back(e);
        ok = 1;
      end
    end
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1");
    end
  endtask

  task automatic send_rand();
    logic [31:0] a, b;
    logic op;
    exp_t e;
    a  = pick();
    b  = pick();
    op = 1'($urandom_range(0, 1));
    e  = model(a, b, op);
    send(a, b, op, e.r, e.f);
  endtask

  task automatic idle();
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  // Monitor: handshake model, stall hold and result scoreboard.
  initial begin
    int   inflight;
    bit   stalled;
    bit   exp_v;
    logic [31:0] prev_res;
    logic [3:0]  prev_f;
    exp_t e;
    stalled = 0;
    prev_res = '0;
    prev_f = '0;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        stalled = 0;
        continue;
      end
      inflight = q.size() - ((in_valid && in_ready) ? 1 : 0);
      chk("in_ready", 32'(in_ready),
          32'((inflight < 2) || out_ready));
      exp_v = (q.size() > 0) && (q[0].cyc + 2 <= cyc);
      chk("out_valid", 32'(out_valid), 32'(exp_v));
      if (stalled) begin
        chk("hold_res", out_res, prev_res);
        chk("hold_flags", 32'({out_c, out_z, out_n, out_v}),
            32'(prev_f));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", 32'(out_valid), 32'h0);
        end else begin
          e = q.pop_front();
          chk("res", out_res, e.r);
          chk("flags_czn_v",
              32'({out_c, out_z, out_n, out_v}), 32'(e.f));
        end
      end
      stalled  = out_valid && !out_ready;
      prev_res = out_res;
      prev_f   = {out_c, out_z, out_n, out_v};
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk); #2;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_out_res", out_res, 32'h0);
    chk("rst_flags", 32'({out_c, out_z, out_n, out_v}), 32'h0);

    send(32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 4'b0000);
    idle();
    send(32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 4'b0010);
    send(32'h0000_0007, 32'h0000_0007, 1'b1, 32'h0000_0000, 4'b1100);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 4'b0011);
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b1100);
    idle();
    repeat (4) @(posedge clk);

    for (int i = 0; i < 8; i++) send_rand();
    idle();
    repeat (4) @(posedge clk);

    fork
      begin
        for (int i = 0; i < 8; i++) send_rand();
        idle();
      end
      begin
        repeat (3) @(posedge clk);
        #2 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #2 out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);

    #2 out_ready = 1'b0;
    send_rand();
    send_rand();
    idle();
    @(negedge clk); #2;
    chk("full_s1_valid", 32'(dut.s1_valid), 32'h1);
    @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
    q.delete();
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk); #2;
    chk("flush_out_valid", 32'(out_valid), 32'h0);
    chk("flush_s1_valid", 32'(dut.s1_valid), 32'h0);
    chk("flush_in_ready", 32'(in_ready), 32'h1);
    chk("flush_out_res", out_res, 32'h0);
    @(posedge clk); #2;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);

    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) idle();
          send_rand();
        end
        idle();
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #2;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join

    @(posedge clk); #2;
    out_ready = 1'b1;
    for (int t = 0; t < 100 && q.size() > 0; t++) @(posedge clk);
    @(negedge clk); #2;
    chk("drain_left", 32'(q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
